// File: rtl/ucsbece154a_mem_bridge.sv
// ucsbece154a_mem_bridge
// Single-port access sequencer between the multicycle datapath and a unified
// instruction/data memory on a variable-latency req/ack bus. Misaligned
// requests are rejected without a bus cycle and end in an error pulse.
// Optional feature macro: UCSBECE154A_MEM_TIMEOUT_EN. When defined, a
// saturating 8-bit wait counter aborts a BUS access after TIMEOUT_CYCLES
// cycles without ack. When undefined, BUS waits indefinitely for ack.
module ucsbece154a_mem_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_adr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i,
  input  logic                  mem_ack_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // Reject out-of-range timeout limits when the design is elaborated.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  // Only the word index is kept: accepted addresses are always word aligned.
  logic [ADDR_WIDTH-3:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef UCSBECE154A_MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

  // Next-state and latch-update logic for the access sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
`ifdef UCSBECE154A_MEM_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (adr_i[1:0] != 2'b00) begin
            state_d = ERR;
          end else begin
            we_d    = we_i;
            adr_d   = adr_i[ADDR_WIDTH-1:2];
            wd_d    = wd_i;
`ifdef UCSBECE154A_MEM_TIMEOUT_EN
            wait_cnt_d = 8'd0;
`endif
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // An ack always wins, even on the cycle the timeout limit is hit.
        if (mem_ack_i) begin
          if (!we_q) rdata_d = mem_rd_i;
          state_d = DONE;
        end else begin
`ifdef UCSBECE154A_MEM_TIMEOUT_EN
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
          if (wait_cnt_q == TIMEOUT_LIM - 8'd1) state_d = ERR;
`endif
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
`ifdef UCSBECE154A_MEM_TIMEOUT_EN
      wait_cnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
`ifdef UCSBECE154A_MEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Outputs decoded only from state and latched registers, so reset drops
  // the bus request at once and no input reaches an output combinationally.
  always_comb begin
    busy_o    = (state_q != IDLE);
    done_o    = (state_q == DONE) || (state_q == ERR);
    err_o     = (state_q == ERR);
    mem_req_o = (state_q == BUS);
    mem_we_o  = (state_q == BUS) && we_q;
    mem_adr_o = {adr_q, 2'b00};
    mem_wd_o  = wd_q;
    rdata_o   = rdata_q;
  end

endmodule
